// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC control unit.
package pc_ctrl_pkg;

  // Sequencer states; any other encoding is treated as illegal and recovers to ST_BOOT.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STALL  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } pc_state_e;

  localparam int                REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds either ID source.
// x0 is never a real dependency, so a load targeting x0 never stalls.
module load_use_detect
  import pc_ctrl_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  // Pure combinational compare, evaluated every cycle.
  always_comb begin
    hazard = ex_mem_read && (ex_rd != REG_X0) &&
             ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pc_control_unit.sv
// Fetch-stage sequencer: drives PC enable/select, IF/ID and ID/EX controls,
// holds a redirect that lands during a memory stall, drains on halt and keeps
// saturating stall/flush statistics.
module pc_control_unit
  import pc_ctrl_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int               DRAIN_CYC = 4,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              mem_busy,
  input  logic              halt_req,
  output logic              pc_write,
  output logic              if_flush,
  output logic [XLEN-1:0]   bj_next,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [2:0]        dbg_state
);

  localparam int               DW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pc_state_e         state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic capture_pend;
  logic clear_pend;
  logic start_drain;
  logic count_flush;
  logic count_stall;
  logic drain_done;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // Drain finishes only when the count is exhausted and memory is not pausing it.
  assign drain_done = (state_q == ST_DRAIN) && !mem_busy && (drain_q == '0);

  // State register plus all other registered bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      drain_q     <= drain_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic; RUN rules are prioritised busy > load-use > halt > branch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN: begin
        if (mem_busy) begin
          if (br_taken) state_d = ST_STALL;
        end else if (!hazard && halt_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_STALL:  if (!mem_busy) state_d = ST_RUN;
      ST_DRAIN:  if (drain_done) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Control outputs; reset forces a safe idle pattern regardless of state.
  always_comb begin
    pc_write     = 1'b0;
    if_flush     = 1'b0;
    bj_next      = '0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    capture_pend = 1'b0;
    clear_pend   = 1'b0;
    start_drain  = 1'b0;
    count_flush  = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_BOOT: begin
          pc_write    = 1'b1;
          if_flush    = 1'b1;
          bj_next     = RESET_PC;
          if_id_flush = 1'b1;
        end
        ST_RUN: begin
          if (mem_busy) begin
            id_ex_bubble = 1'b0;
            capture_pend = br_taken;
          end else if (hazard) begin
            // Stall with a bubble; any branch is re-resolved next cycle.
          end else if (halt_req) begin
            if_id_flush = 1'b1;
            start_drain = 1'b1;
          end else if (br_taken) begin
            pc_write     = 1'b1;
            if_flush     = 1'b1;
            bj_next      = br_target;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
            count_flush  = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
        ST_STALL: begin
          if (mem_busy) begin
            id_ex_bubble = 1'b0;
            capture_pend = br_taken;
          end else if (pend_v_q) begin
            pc_write     = 1'b1;
            if_flush     = 1'b1;
            bj_next      = pend_addr_q;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
            clear_pend   = 1'b1;
            count_flush  = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
        ST_DRAIN: begin
          if_id_flush = 1'b1;
        end
        default: begin
          // HALTED and illegal encodings: everything frozen, bubbles into EX.
        end
      endcase
    end
  end

  // Pending redirect, drain countdown, halt flag and saturating statistics.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    drain_d     = drain_q;
    halted_d    = halted_q | drain_done;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    count_stall = rst_n && ((state_q == ST_RUN) || (state_q == ST_STALL)) && !pc_write;

    if (capture_pend) begin
      pend_v_d    = 1'b1;
      pend_addr_d = br_target;
    end else if (clear_pend) begin
      pend_v_d    = 1'b0;
    end

    if (start_drain) begin
      drain_d = DW'(DRAIN_CYC - 1);
    end else if ((state_q == ST_DRAIN) && !mem_busy && (drain_q != '0)) begin
      drain_d = drain_q - 1'b1;
    end

    if (count_stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (count_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit. A second instance with 2-bit counters
// shares all inputs so counter saturation is reached within a few stalls.
module tb_pc_control_unit;
  import pc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rst_drv = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        mem_busy = 1'b0;
  logic        halt_req = 1'b0;

  logic        pc_write, if_flush, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [31:0] bj_next;
  logic [15:0] stall_cnt, flush_cnt;
  logic [2:0]  dbg_state;

  logic        s_pc_write, s_if_flush, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_halted;
  logic [31:0] s_bj_next;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic [2:0]  s_dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  pc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .br_target(br_target),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_write(pc_write), .if_flush(if_flush), .bj_next(bj_next),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  pc_control_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .br_target(br_target),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_write(s_pc_write), .if_flush(s_if_flush), .bj_next(s_bj_next),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
  );

  // ---------------- driver ----------------
  // Apply one cycle of inputs just after the falling edge, then let outputs settle.
  task automatic drive(input logic br, input logic [31:0] tgt, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic busy, input logic halt);
    @(negedge clk);
    rst_n       = rst_drv;
    br_taken    = br;
    br_target   = tgt;
    ex_mem_read = mr;
    ex_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    mem_busy    = busy;
    halt_req    = halt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held
    rst_drv = 1'b0;
    idle();
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_if_flush", 32'(if_flush), 32'd0);
    chk("rst_if_id_write", 32'(if_id_write), 32'd0);
    chk("rst_bubble", 32'(id_ex_bubble), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Reset release: BOOT then RUN
    rst_drv = 1'b1;
    idle();
    chk("boot_state", 32'(dbg_state), 32'(ST_BOOT));
    chk("boot_pc_write", 32'(pc_write), 32'd1);
    chk("boot_if_flush", 32'(if_flush), 32'd1);
    chk("boot_bj_next", bj_next, 32'h0);
    chk("boot_if_id_flush", 32'(if_id_flush), 32'd1);
    idle();
    chk("run_pc_write", 32'(pc_write), 32'd1);
    chk("run_if_flush", 32'(if_flush), 32'd0);
    chk("run_bj_next", bj_next, 32'h0);
    chk("run_if_id_write", 32'(if_id_write), 32'd1);
    chk("run_bubble", 32'(id_ex_bubble), 32'd0);

    // Taken branch in RUN
    drive(1'b1, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    chk("br_if_flush", 32'(if_flush), 32'd1);
    chk("br_bj_next", bj_next, 32'h40);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_flush_cnt_before", 32'(flush_cnt), 32'd0);
    idle();
    chk("br_flush_cnt_after", 32'(flush_cnt), 32'd1);
    chk("br_if_flush_after", 32'(if_flush), 32'd0);

    // Load-use on rs2 masks a taken branch
    drive(1'b1, 32'h99, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    chk("lu_if_flush", 32'(if_flush), 32'd0);
    chk("lu_bj_next", bj_next, 32'h0);
    // Same with ex_rd = x0: no hazard, the branch now redirects
    drive(1'b1, 32'h99, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    chk("x0_if_flush", 32'(if_flush), 32'd1);
    chk("x0_bj_next", bj_next, 32'h99);
    // Load-use on rs1
    drive(1'b0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
    chk("lu1_pc_write", 32'(pc_write), 32'd0);
    chk("lu1_flush_cnt", 32'(flush_cnt), 32'd2);
    idle();
    chk("lu1_stall_cnt", 32'(stall_cnt), 32'd2);

    // Memory busy 3 cycles with a branch on the first
    drive(1'b1, 32'h80, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("mb_pc_write", 32'(pc_write), 32'd0);
    chk("mb_if_id_write", 32'(if_id_write), 32'd0);
    chk("mb_bubble", 32'(id_ex_bubble), 32'd0);
    chk("mb_if_flush", 32'(if_flush), 32'd0);
    chk("mb_if_id_flush", 32'(if_id_flush), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("mb2_state", 32'(dbg_state), 32'(ST_STALL));
    chk("mb2_pc_write", 32'(pc_write), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("mb3_pc_write", 32'(pc_write), 32'd0);
    idle();
    chk("mb_rel_pc_write", 32'(pc_write), 32'd1);
    chk("mb_rel_if_flush", 32'(if_flush), 32'd1);
    chk("mb_rel_bj_next", bj_next, 32'h80);
    chk("mb_rel_if_id_flush", 32'(if_id_flush), 32'd1);
    idle();
    chk("mb_state_run", 32'(dbg_state), 32'(ST_RUN));
    chk("mb_if_flush_after", 32'(if_flush), 32'd0);
    chk("mb_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("mb_flush_cnt", 32'(flush_cnt), 32'd3);
    chk("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);

    // Pending redirect: last branch during the stall wins
    drive(1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h200, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("lw_state", 32'(dbg_state), 32'(ST_STALL));
    idle();
    chk("lw_if_flush", 32'(if_flush), 32'd1);
    chk("lw_bj_next", bj_next, 32'h200);
    idle();
    chk("lw_stall_cnt", 32'(stall_cnt), 32'd7);
    chk("lw_flush_cnt", 32'(flush_cnt), 32'd4);
    chk("sat_stall_cnt2", 32'(s_stall_cnt), 32'd3);
    chk("sat_flush_cnt", 32'(s_flush_cnt), 32'd3);
    chk("sat_state", 32'(s_dbg_state), 32'(ST_RUN));

    // Halt and drain
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("halt_pc_write", 32'(pc_write), 32'd0);
    chk("halt_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("halt_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("drain%0d_state", i), 32'(dbg_state), 32'(ST_DRAIN));
      chk($sformatf("drain%0d_if_id_flush", i), 32'(if_id_flush), 32'd1);
      chk($sformatf("drain%0d_pc_write", i), 32'(pc_write), 32'd0);
      chk($sformatf("drain%0d_bubble", i), 32'(id_ex_bubble), 32'd1);
      chk($sformatf("drain%0d_halted", i), 32'(halted), 32'd0);
    end
    drive(1'b1, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("hlt_state", 32'(dbg_state), 32'(ST_HALTED));
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_pc_write", 32'(pc_write), 32'd0);
    chk("hlt_if_flush", 32'(if_flush), 32'd0);
    chk("hlt_if_id_flush", 32'(if_id_flush), 32'd0);
    chk("hlt_bubble", 32'(id_ex_bubble), 32'd1);
    chk("hlt_stall_cnt", 32'(stall_cnt), 32'd8);
    idle();
    chk("hlt_halted_hold", 32'(halted), 32'd1);
    chk("hlt_pc_write_hold", 32'(pc_write), 32'd0);

    // Reset out of HALTED
    rst_drv = 1'b0;
    drive(1'b1, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst2_pc_write", 32'(pc_write), 32'd0);
    chk("rst2_if_flush", 32'(if_flush), 32'd0);
    chk("rst2_bubble", 32'(id_ex_bubble), 32'd1);
    rst_drv = 1'b1;
    idle();
    chk("rst2_state", 32'(dbg_state), 32'(ST_BOOT));
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst2_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst2_bj_next", bj_next, 32'h0);
    chk("rst2_sat_stall", 32'(s_stall_cnt), 32'd0);

    // Reset mid-stall discards the pending redirect
    idle();
    drive(1'b1, 32'h300, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    rst_drv = 1'b0;
    idle();
    rst_drv = 1'b1;
    idle();
    chk("rst3_state", 32'(dbg_state), 32'(ST_BOOT));
    chk("rst3_bj_next", bj_next, 32'h0);
    idle();
    chk("rst3_state_run", 32'(dbg_state), 32'(ST_RUN));
    chk("rst3_if_flush", 32'(if_flush), 32'd0);
    chk("rst3_pc_write", 32'(pc_write), 32'd1);
    chk("rst3_flush_cnt", 32'(flush_cnt), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
